// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: 10b symbol -> 8b data or 2b control token,
// with a bitslip-driven word-alignment search and lock tracker.
module tmds_decoder #(
  parameter int LOCK_CTRL_COUNT = 16,
  parameter int SEARCH_TIMEOUT  = 4096,
  parameter int SLIP_SETTLE     = 4,
  parameter int LOSS_TIMEOUT    = 4096
) (
  input  logic       pix_clk,
  input  logic       rst_n,
  input  logic [9:0] sym_in,
  input  logic       sym_valid,
  output logic [7:0] data_out,
  output logic [1:0] ctrl_out,
  output logic       de_out,
  output logic       out_valid,
  output logic       locked,
  output logic       bitslip,
  output logic [3:0] slip_count
);

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  ctrl_run;
  logic [15:0] timer;
  logic [3:0]  settle;

  logic        is_ctrl;
  logic [1:0]  token;
  logic [7:0]  d;
  logic [7:0]  x;
  logic [7:0]  dec;
  logic [7:0]  run_next;
  logic        run_complete;
  logic        search_expired;
  logic        loss_expired;

  // Symbol classification and data decode.
  always_comb begin
    is_ctrl = 1'b1;
    token   = 2'b00;
    case (sym_in)
      10'b1101010100: token = 2'b00;
      10'b0010101011: token = 2'b01;
      10'b0101010100: token = 2'b10;
      10'b1010101011: token = 2'b11;
      default: begin
        is_ctrl = 1'b0;
        token   = 2'b00;
      end
    endcase
    d = sym_in[9] ? ~sym_in[7:0] : sym_in[7:0];
    x = d ^ {d[6:0], 1'b0};
    if (sym_in[8]) begin
      dec = {x[7:1], d[0]};
    end else begin
      dec = {~x[7:1], d[0]};
    end
  end

  // Run completion fires only on the token that reaches the threshold, never on saturation.
  always_comb begin
    if (!is_ctrl) begin
      run_next = 8'd0;
    end else if (ctrl_run == 8'(LOCK_CTRL_COUNT)) begin
      run_next = ctrl_run;
    end else begin
      run_next = ctrl_run + 8'd1;
    end
    run_complete   = sym_valid && is_ctrl && (state != SLIP) &&
                     (ctrl_run == 8'(LOCK_CTRL_COUNT - 1));
    search_expired = (timer == 16'(SEARCH_TIMEOUT - 1));
    loss_expired   = (timer == 16'(LOSS_TIMEOUT - 1));
  end

  // Registered decode outputs.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out  <= 8'd0;
      ctrl_out  <= 2'd0;
      de_out    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= sym_valid && (state == LOCKED);
      if (sym_valid) begin
        if (is_ctrl) begin
          de_out   <= 1'b0;
          ctrl_out <= token;
        end else begin
          de_out   <= 1'b1;
          data_out <= dec;
        end
      end
    end
  end

  // Alignment state machine with registered lock/bitslip outputs.
  always_ff @(posedge pix_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      ctrl_run   <= 8'd0;
      timer      <= 16'd0;
      settle     <= 4'd0;
      locked     <= 1'b0;
      bitslip    <= 1'b0;
      slip_count <= 4'd0;
    end else begin
      case (state)
        SEARCH: begin
          bitslip <= 1'b0;
          locked  <= 1'b0;
          if (sym_valid) begin
            ctrl_run <= run_next;
            if (run_complete) begin
              state  <= LOCKED;
              locked <= 1'b1;
              timer  <= 16'd0;
            end else if (search_expired) begin
              state      <= SLIP;
              bitslip    <= 1'b1;
              slip_count <= slip_count + 4'd1;
              timer      <= 16'd0;
              settle     <= 4'd0;
              ctrl_run   <= 8'd0;
            end else begin
              timer <= timer + 16'd1;
            end
          end
        end
        SLIP: begin
          // Settle count starts after the bitslip cycle, so SLIP spans 1 + SLIP_SETTLE cycles.
          bitslip  <= 1'b0;
          locked   <= 1'b0;
          ctrl_run <= 8'd0;
          if (settle == 4'(SLIP_SETTLE)) begin
            state  <= SEARCH;
            timer  <= 16'd0;
            settle <= 4'd0;
          end else begin
            settle <= settle + 4'd1;
          end
        end
        LOCKED: begin
          bitslip <= 1'b0;
          if (sym_valid) begin
            ctrl_run <= run_next;
            if (run_complete) begin
              timer <= 16'd0;
            end else if (loss_expired) begin
              state    <= SEARCH;
              locked   <= 1'b0;
              timer    <= 16'd0;
              ctrl_run <= 8'd0;
            end else begin
              timer <= timer + 16'd1;
            end
          end
        end
        default: begin
          state    <= SEARCH;
          bitslip  <= 1'b0;
          locked   <= 1'b0;
          ctrl_run <= 8'd0;
          timer    <= 16'd0;
          settle   <= 4'd0;
        end
      endcase
    end
  end

endmodule
